// File: rtl/disp_ctrl.sv
// disp_ctrl: SFR-bus front end producing the 16-bit seven-segment display word
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   wr, rd        single-cycle write / read strobes
//   addr[1:0]     0 LO, 1 HI (commit), 2 CTRL {FREEZE, MODE}, 3 STATUS {sync_evt, MODE, ovf}
//   wdata[7:0]    write data
//   rdata[7:0]    registered read data, held until the next rd
//   evt           asynchronous event input, counted in counter mode
//   hex[15:0]     display word, [3:0] is the rightmost digit
//   upd           one-cycle pulse per commit or count reaching hex
//
// Build option: DISP_CTRL_BCD_EN selects a four-digit BCD counter instead of binary.
module disp_ctrl #(
    parameter logic [15:0] RESET_VALUE = 16'h0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr,
    input  logic        rd,
    input  logic [1:0]  addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    input  logic        evt,
    output logic [15:0] hex,
    output logic        upd
);

    // Returns {wrap, next}; wrap flags the roll-over to 0000.
    function automatic logic [16:0] incr(input logic [15:0] v);
`ifdef DISP_CTRL_BCD_EN
        logic        c;
        logic [15:0] r;
        c = 1'b1;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return {c, r};
`else
        return {1'b0, v} + 17'd1;
`endif
    endfunction

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   evt_prev_q, evt_prev_d;
    logic [15:0]            counter_q, counter_d;
    logic [15:0]            hex_q, hex_d;
    logic [7:0]             lo_q, lo_d;
    logic [1:0]             ctrl_q, ctrl_d;
    logic                   ovf_q, ovf_d;
    logic [7:0]             rdata_q, rdata_d;
    logic                   upd_q, upd_d;
    logic                   sync_evt, rise, commit, inc, stat_rd, carry;
    logic [15:0]            nxt;

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], evt};
        sync_evt   = sync_q[SYNC_STAGES-1];
        evt_prev_d = sync_evt;
        rise       = sync_evt & ~evt_prev_q;
        commit     = wr && addr == 2'd1;
        // Commit has priority; an edge arriving in the same cycle is dropped.
        inc        = ctrl_q[0] && rise && !commit;
        {carry, nxt} = incr(counter_q);
        stat_rd    = rd && addr == 2'd3;
        lo_d       = (wr && addr == 2'd0) ? wdata : lo_q;
        ctrl_d     = (wr && addr == 2'd2) ? wdata[1:0] : ctrl_q;
        counter_d  = commit ? {wdata, lo_q} : inc ? nxt : counter_q;
        // A wrap in the same cycle as a STATUS read keeps ovf set.
        ovf_d      = (inc && carry) || (ovf_q && !stat_rd);
        hex_d      = ctrl_d[1] ? hex_q : counter_d;
        upd_d      = (commit || inc) && !ctrl_d[1];
        rdata_d    = !rd           ? rdata_q :
                     addr == 2'd0  ? lo_q :
                     addr == 2'd1  ? counter_q[15:8] :
                     addr == 2'd2  ? {6'd0, ctrl_q} :
                                     {5'd0, sync_evt, ctrl_q[0], ovf_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= '0;
            evt_prev_q <= 1'b0;
            counter_q  <= RESET_VALUE;
            hex_q      <= RESET_VALUE;
            lo_q       <= 8'd0;
            ctrl_q     <= 2'd0;
            ovf_q      <= 1'b0;
            rdata_q    <= 8'd0;
            upd_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            evt_prev_q <= evt_prev_d;
            counter_q  <= counter_d;
            hex_q      <= hex_d;
            lo_q       <= lo_d;
            ctrl_q     <= ctrl_d;
            ovf_q      <= ovf_d;
            rdata_q    <= rdata_d;
            upd_q      <= upd_d;
        end
    end

    assign rdata = rdata_q;
    assign hex   = hex_q;
    assign upd   = upd_q;

endmodule

// File: tb/tb_disp_ctrl.sv
// tb_disp_ctrl: directed self-checking bench for disp_ctrl
module tb_disp_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [7:0]  wdata = 8'd0;
    logic [7:0]  rdata;
    logic        evt = 1'b0;
    logic [15:0] hex;
    logic        upd;

    int          total = 0;
    int          bad = 0;
    logic        upd_seen;
    logic [7:0]  r;
    logic [15:0] g;

    disp_ctrl dut (
        .clk(clk), .rst(rst), .wr(wr), .rd(rd), .addr(addr), .wdata(wdata),
        .rdata(rdata), .evt(evt), .hex(hex), .upd(upd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
        wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
        rd = 1'b1; addr = a;
        @(negedge clk);
        rd = 1'b0;
        d = rdata;
    endtask

    task automatic pulse(input int hi, input int lo);
        evt = 1'b1;
        repeat (hi) begin @(negedge clk); upd_seen |= upd; end
        evt = 1'b0;
        repeat (lo) begin @(negedge clk); upd_seen |= upd; end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_hex", hex, 16'h0000);
        check("rst_upd", upd, 1'b0);
        check("rst_rdata", rdata, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        bus_wr(2'd2, 8'h01);
        pulse(4, 4);
        pulse(4, 4);
        check("pre_rst_count", hex, 16'h0002);
        bus_wr(2'd0, 8'h55);
        bus_rd(2'd3, r);
        check("pre_rst_status", r, 8'h02);
        rst = 1'b1;
        #1;
        check("async_rst_hex", hex, 16'h0000);
        check("async_rst_rdata", rdata, 8'h00);
        check("async_rst_upd", upd, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus_rd(2'd0, r);
        check("lo_discarded", r, 8'h00);
        bus_rd(2'd2, r);
        check("ctrl_cleared", r, 8'h00);
        bus_rd(2'd3, r);
        check("status_cleared", r, 8'h00);

        bus_wr(2'd0, 8'h34);
        check("lo_no_hex", hex, 16'h0000);
        check("lo_no_upd", upd, 1'b0);
        bus_wr(2'd1, 8'h12);
        check("commit_hex", hex, 16'h1234);
        check("commit_upd", upd, 1'b1);
        @(negedge clk);
        check("commit_upd_end", upd, 1'b0);
        bus_rd(2'd1, r);
        check("rd_hi", r, 8'h12);
        bus_rd(2'd0, r);
        check("rd_lo", r, 8'h34);

        bus_wr(2'd0, 8'h00);
        bus_wr(2'd1, 8'h00);
        bus_wr(2'd2, 8'h01);
        for (int i = 0; i < 5; i++) begin
            evt = 1'b1;
            @(negedge clk);
            @(negedge clk);
            check("lat_before", hex, i);
            @(negedge clk);
            check("lat_at", hex, i + 1);
            check("lat_upd", upd, 1'b1);
            @(negedge clk);
            check("lat_upd_end", upd, 1'b0);
            evt = 1'b0;
            repeat (4) @(negedge clk);
        end
        check("count5", hex, 16'h0005);

        bus_wr(2'd2, 8'h00);
        pulse(4, 4);
        check("reg_mode_ignores", hex, 16'h0005);

`ifdef DISP_CTRL_BCD_EN
        bus_wr(2'd2, 8'h01);
        bus_wr(2'd0, 8'h98);
        bus_wr(2'd1, 8'h99);
        pulse(4, 4);
        check("bcd_9999", hex, 16'h9999);
        pulse(4, 4);
        check("bcd_wrap", hex, 16'h0000);
        bus_wr(2'd2, 8'h00);
        bus_rd(2'd3, r);
        check("wrap_status", r, 8'h01);
        bus_rd(2'd3, r);
        check("wrap_status_clr", r, 8'h00);
        bus_wr(2'd2, 8'h01);
        bus_wr(2'd0, 8'h99);
        bus_wr(2'd1, 8'h00);
        pulse(4, 4);
        check("bcd_carry", hex, 16'h0100);
`else
        bus_wr(2'd2, 8'h01);
        bus_wr(2'd0, 8'hFE);
        bus_wr(2'd1, 8'hFF);
        pulse(4, 4);
        check("bin_ffff", hex, 16'hFFFF);
        pulse(4, 4);
        check("bin_wrap", hex, 16'h0000);
        bus_wr(2'd2, 8'h00);
        bus_rd(2'd3, r);
        check("wrap_status", r, 8'h01);
        bus_rd(2'd3, r);
        check("wrap_status_clr", r, 8'h00);
`endif

        bus_wr(2'd2, 8'h01);
        bus_wr(2'd0, 8'h00);
        evt = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus_wr(2'd1, 8'h77);
        check("collide_commit", hex, 16'h7700);
        repeat (3) @(negedge clk);
        check("collide_no_inc", hex, 16'h7700);
        evt = 1'b0;
        repeat (4) @(negedge clk);

`ifdef DISP_CTRL_BCD_EN
        bus_wr(2'd0, 8'h99);
        bus_wr(2'd1, 8'h99);
`else
        bus_wr(2'd0, 8'hFF);
        bus_wr(2'd1, 8'hFF);
`endif
        evt = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus_rd(2'd3, r);
        check("rd_wrap_same", r, 8'h06);
        check("rd_wrap_hex", hex, 16'h0000);
        bus_rd(2'd3, r);
        check("rd_wrap_next", r, 8'h07);
        evt = 1'b0;
        repeat (4) @(negedge clk);

        bus_wr(2'd0, 8'h10);
        bus_wr(2'd1, 8'h00);
        bus_wr(2'd2, 8'h03);
        upd_seen = 1'b0;
        repeat (3) pulse(4, 4);
        check("freeze_hex", hex, 16'h0010);
        check("freeze_upd", upd_seen, 1'b0);
        bus_wr(2'd2, 8'h01);
        check("unfreeze_hex", hex, 16'h0013);

        evt = 1'b1;
        @(negedge clk);
        evt = 1'b0;
        repeat (8) @(negedge clk);
        check("glitch_at_most_one", (hex == 16'h0013) || (hex == 16'h0014), 1'b1);
        g = hex;
        pulse(4, 4);
        check("after_glitch_one", hex, g + 16'd1);

        bus_wr(2'd2, 8'hFF);
        bus_rd(2'd2, r);
        check("ctrl_mask", r, 8'h03);
        bus_wr(2'd3, 8'h00);
        bus_rd(2'd2, r);
        check("status_wr_ignored", r, 8'h03);
        bus_rd(2'd3, r);
        check("status_final", r, 8'h02);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
